matmul_seq: RTL
===============

MATMUL_SEQ -- requirements
Module: matmul_seq

Interface
REQ-001 Parameter N, default 4: square matrix dimension.
REQ-002 Parameter DW, default 8: element width, unsigned.
REQ-003 Parameter AW, default 5: memory address width.
REQ-004 Parameters A_BASE and B_BASE, default 0 and 0: base addresses of A in memory A and of B in memory B.
REQ-005 clk  in  1  single clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, synchronous and active-high.
REQ-007 start  in  1  one-cycle request to compute C = A*B.
REQ-008 a_addr  out  AW  address into memory A; a_rd  out  1  read enable to memory A.
REQ-009 a_data  in  DW  memory A read data, combinational from a_addr when a_rd is high.
REQ-010 b_addr  out  AW; b_rd  out  1; b_data  in  DW  as REQ-008/009, for memory B.
REQ-011 c_data  out  2*DW+clog2(N)  result element; c_row, c_col  out  clog2(N) each  element index.
REQ-012 c_valid  out  1; c_ready  in  1  result handshake.
REQ-013 busy  out  1  high from the first MAC cycle until done; done  out  1  one-cycle completion pulse.

Function
REQ-014 A[i][k] SHALL be read at A_BASE + i*N + k, and B[k][j] at B_BASE + k*N + j, row-major, modulo 2^AW.
REQ-015 FSM states SHALL be IDLE, MAC, EMIT and FIN.
REQ-016 In IDLE, start=1 SHALL clear i, j, k and the accumulator, then enter MAC on the next cycle; start is ignored in every other state.
REQ-017 In MAC, a_rd=b_rd=1 with addresses for the current (i,k,j), and acc <= acc + a_data*b_data at each edge.
REQ-018 k SHALL advance once per MAC cycle; after k=N-1 the FSM enters EMIT, so each element takes exactly N MAC cycles.
REQ-019 Outside MAC, a_rd=b_rd=0 and the addresses hold their last values.
REQ-020 In EMIT, c_valid=1, c_data=acc, c_row=i, c_col=j, all stable until c_valid && c_ready at a rising edge.
REQ-021 On handshake, acc SHALL clear and j SHALL advance; at j=N-1, j wraps to 0 and i advances.
REQ-022 After the handshake for a non-final element, the FSM re-enters MAC with k=0.
REQ-023 After the handshake for the final element (i=j=N-1), the FSM enters FIN.
REQ-024 FIN SHALL assert done for one cycle, deassert busy, and return to IDLE.
REQ-025 With c_ready held high, start-to-done SHALL take N*N*(N+1)+1 cycles (81 for N=4).
REQ-026 The accumulator SHALL be 2*DW+clog2(N) bits, unsigned; overflow is impossible by construction.
REQ-027 Results SHALL be emitted in row-major order (i outer, j inner).

Reset
REQ-028 rst=1 at a rising edge SHALL force IDLE from any state, including mid-MAC and mid-EMIT.
REQ-029 Reset values: i=j=k=0, acc=0, a_addr=b_addr=0, a_rd=b_rd=0, c_valid=0, c_data=0, c_row=c_col=0, busy=0, done=0.
REQ-030 An element pending in EMIT at reset SHALL be discarded without a handshake.

Structure
REQ-031 Shared package matmul_pkg SHALL hold the default N, DW and AW and the FSM state enumeration.
REQ-032 Sub-module matmul_mac SHALL contain the multiply-accumulate register, with inputs clear, enable and the two operands.

Verification
REQ-033 A = identity, B[r][c] = 4r+c, c_ready=1: 16 outputs with c_data = 4*row+col in row-major order, done at cycle 81.
REQ-034 All A and B entries 255: every c_data = 260100.
REQ-035 c_ready held low for 3 cycles at element (0,1): c_valid and c_data stay stable 3 cycles; no MAC reads occur; total latency grows by 3.
REQ-036 start pulsed during MAC of element (2,2): no restart, output sequence unchanged.
REQ-037 rst during element (1,3): all outputs reach reset values next cycle; a subsequent start reproduces the full correct result.
REQ-038 A_BASE=16, B_BASE=8: first four reads are a_addr 16,17,18,19 paired with b_addr 8,12,16,20.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the sequential matrix multiplier: default sizes,
// FSM state encoding and width helpers used by the top, MAC and interface.
package matmul_pkg;

   localparam int N_DEF  = 4;
   localparam int DW_DEF = 8;
   localparam int AW_DEF = 5;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MAC  = 2'd1,
      EMIT = 2'd2,
      FIN  = 2'd3
   } state_t;

   // Width of a row/column/k index; a 1x1 matrix still needs one bit.
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Accumulator width: an N-term sum of DW x DW products never overflows.
   function automatic int acc_w(input int n, input int dw);
      return 2 * dw + $clog2(n);
   endfunction

endpackage

// File: rtl/matmul_if.sv
// Memory-read and result-stream signals of the matrix multiplier.
// master = the multiplier, slave = memories plus the result consumer.
//
// Result handshake: c_valid/c_ready. An element transfers on a rising edge
// where both are high. Once c_valid is raised, c_valid, c_data, c_row and
// c_col hold steady until that transfer; c_ready may toggle freely.
interface matmul_if #(
   parameter int N  = matmul_pkg::N_DEF,
   parameter int DW = matmul_pkg::DW_DEF,
   parameter int AW = matmul_pkg::AW_DEF
);
   localparam int IW = matmul_pkg::idx_w(N);
   localparam int CW = matmul_pkg::acc_w(N, DW);

   logic [AW-1:0] a_addr;
   logic          a_rd;
   logic [DW-1:0] a_data;
   logic [AW-1:0] b_addr;
   logic          b_rd;
   logic [DW-1:0] b_data;
   logic [CW-1:0] c_data;
   logic [IW-1:0] c_row;
   logic [IW-1:0] c_col;
   logic          c_valid;
   logic          c_ready;

   modport master (
      output a_addr, a_rd, input a_data,
      output b_addr, b_rd, input b_data,
      output c_data, c_row, c_col, c_valid,
      input  c_ready
   );

   modport slave (
      input  a_addr, a_rd, output a_data,
      input  b_addr, b_rd, output b_data,
      input  c_data, c_row, c_col, c_valid,
      output c_ready
   );

endinterface

// File: rtl/matmul_mac.sv
// Multiply-accumulate register: acc <= acc + op_a*op_b when enabled.
// clear has priority over enable so a new element always starts from zero.
module matmul_mac
   import matmul_pkg::*;
#(
   parameter int DW = DW_DEF,
   parameter int CW = acc_w(N_DEF, DW_DEF)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clear,
   input  logic          enable,
   input  logic [DW-1:0] op_a,
   input  logic [DW-1:0] op_b,
   output logic [CW-1:0] acc
);

   logic [2*DW-1:0] prod;

   assign prod = {{DW{1'b0}}, op_a} * {{DW{1'b0}}, op_b};

   // Accumulate one product per enabled cycle; reset or clear zeroes it.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         acc <= '0;
      end else if (enable) begin
         acc <= acc + CW'(prod);
      end
   end

endmodule

// File: rtl/matmul_seq.sv
// Sequential C = A*B over two external read-only memories. One MAC per cycle:
// each element takes N MAC cycles, then waits in EMIT for the result
// handshake. Elements are produced row-major (i outer, j inner).
module matmul_seq
   import matmul_pkg::*;
#(
   parameter int N      = N_DEF,
   parameter int DW     = DW_DEF,
   parameter int AW     = AW_DEF,
   parameter int A_BASE = 0,
   parameter int B_BASE = 0
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   start,
   matmul_if.master bus,
   output logic   busy,
   output logic   done,
   output state_t state_dbg
);

   localparam int IW = idx_w(N);
   localparam int CW = acc_w(N, DW);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   state_t        state;
   state_t        state_n;
   logic [IW-1:0] i_q;
   logic [IW-1:0] j_q;
   logic [IW-1:0] k_q;
   logic [AW-1:0] a_addr_q;
   logic [AW-1:0] b_addr_q;
   logic [AW-1:0] a_addr_n;
   logic [AW-1:0] b_addr_n;
   logic [CW-1:0] acc;
   logic          mac_clr;
   logic          mac_en;
   logic          last_i;
   logic          last_j;
   logic          last_k;

   assign last_i = (i_q == LAST);
   assign last_j = (j_q == LAST);
   assign last_k = (k_q == LAST);

   // Row-major addresses; the AW-bit arithmetic wraps modulo 2^AW.
   assign a_addr_n = AW'(A_BASE) + AW'(i_q) * AW'(N) + AW'(k_q);
   assign b_addr_n = AW'(B_BASE) + AW'(k_q) * AW'(N) + AW'(j_q);

   // State register; reset abandons any element in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_n;
      end
   end

   // Next state and MAC control; start only matters in IDLE.
   always_comb begin
      state_n = state;
      mac_clr = 1'b0;
      mac_en  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               mac_clr = 1'b1;
               state_n = MAC;
            end
         end
         MAC: begin
            mac_en = 1'b1;
            if (last_k) begin
               state_n = EMIT;
            end
         end
         EMIT: begin
            if (bus.c_ready) begin
               mac_clr = 1'b1;
               state_n = (last_i && last_j) ? FIN : MAC;
            end
         end
         FIN: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Loop indices and the last-issued read addresses.
   always_ff @(posedge clk) begin
      if (rst) begin
         i_q      <= '0;
         j_q      <= '0;
         k_q      <= '0;
         a_addr_q <= '0;
         b_addr_q <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  i_q <= '0;
                  j_q <= '0;
                  k_q <= '0;
               end
            end
            MAC: begin
               k_q      <= last_k ? '0 : k_q + 1'b1;
               a_addr_q <= a_addr_n;
               b_addr_q <= b_addr_n;
            end
            EMIT: begin
               if (bus.c_ready) begin
                  j_q <= last_j ? '0 : j_q + 1'b1;
                  if (last_j) begin
                     i_q <= last_i ? '0 : i_q + 1'b1;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   matmul_mac #(
      .DW(DW),
      .CW(CW)
   ) u_mac (
      .clk    (clk),
      .rst    (rst),
      .clear  (mac_clr),
      .enable (mac_en),
      .op_a   (bus.a_data),
      .op_b   (bus.b_data),
      .acc    (acc)
   );

   // Reads are live only in MAC; otherwise the bus parks on the last address.
   assign bus.a_rd   = (state == MAC);
   assign bus.b_rd   = (state == MAC);
   assign bus.a_addr = (state == MAC) ? a_addr_n : a_addr_q;
   assign bus.b_addr = (state == MAC) ? b_addr_n : b_addr_q;

   assign bus.c_valid = (state == EMIT);
   assign bus.c_data  = (state == EMIT) ? acc : '0;
   assign bus.c_row   = i_q;
   assign bus.c_col   = j_q;

   assign busy      = (state == MAC) || (state == EMIT);
   assign done      = (state == FIN);
   assign state_dbg = state;

endmodule
